// File: rtl/fan_cmd_scheduler.sv
// fan_cmd_scheduler
//   Upstream stage of packet_generator. Buffers fan command requests in a
//   small FIFO and plays each command out as REPEATS back-to-back packets.
//   packet_generator reports no completion, so the packet length and the
//   inter-packet gap are timed here with a down-counter.
//
// Ports
//   ref_clk      clock, rising edge
//   reset        synchronous, active-high
//   req_valid    request present
//   req_cmd      requested command code (0..4 valid)
//   req_ready    FIFO not full
//   cmd          command to packet_generator, held for the packet+gap window
//   start        one-clock pulse launching a packet
//   busy         high whenever the sequencer is not idle
//   queue_count  FIFO occupancy
//   drop_err     one-clock pulse after an accepted code 5..7 was discarded
//   state_dbg    current sequencer state, for observation only
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready depends only on the registered
// occupancy, never on req_valid, so a full FIFO that pops this cycle still
// refuses the request; it is accepted on the following edge.
module fan_cmd_scheduler #(
    parameter int PACKET_CYCLES = 85917,
    parameter int GAP_CYCLES    = 22030,
    parameter int REPEATS       = 4,
    parameter int DEPTH_LOG2    = 2,
    parameter int TIMER_WIDTH   = 17
) (
    input  logic                  ref_clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [2:0]            req_cmd,
    output logic                  req_ready,
    output logic [2:0]            cmd,
    output logic                  start,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   queue_count,
    output logic                  drop_err,
    output logic [1:0]            state_dbg
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int REP_W = $clog2(REPEATS + 1);

    localparam logic [DEPTH_LOG2:0]  CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]  CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
    localparam logic [TIMER_WIDTH-1:0] PKT_LOAD = TIMER_WIDTH'(PACKET_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] GAP_LOAD = TIMER_WIDTH'(GAP_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TMR_ONE  = TIMER_WIDTH'(1);
    localparam logic [REP_W-1:0]       REP_LOAD = REP_W'(REPEATS - 1);
    localparam logic [REP_W-1:0]       REP_ONE  = REP_W'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        PACKET = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [REP_W-1:0]       rep_left_q, rep_left_d;
    logic [2:0]             cmd_q, cmd_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;
    logic                   drop_err_q, drop_err_d;
    logic [2:0]             mem_q [DEPTH];
    logic [2:0]             mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    count_q, count_d;

    logic accept;
    logic push;
    logic pop;

    assign req_ready   = (count_q != CNT_FULL);
    assign cmd         = cmd_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign queue_count = count_q;
    assign drop_err    = drop_err_q;
    assign state_dbg   = state_q;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        rep_left_d = rep_left_q;
        cmd_d      = cmd_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pop        = 1'b0;

        accept     = req_valid && req_ready;
        push       = accept && (req_cmd <= 3'd4);
        drop_err_d = accept && (req_cmd > 3'd4);

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    cmd_d      = mem_q[rd_ptr_q];
                    rep_left_d = REP_LOAD;
                    state_d    = SEND;
                end
            end
            SEND: begin
                timer_d = PKT_LOAD;
                state_d = PACKET;
            end
            PACKET: begin
                if (timer_q == '0) begin
                    timer_d = GAP_LOAD;
                    state_d = GAP;
                end else begin
                    timer_d = timer_q - TMR_ONE;
                end
            end
            GAP: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TMR_ONE;
                end else if (rep_left_q != '0) begin
                    // Another repeat of the same command; cmd stays put.
                    rep_left_d = rep_left_q - REP_ONE;
                    state_d    = SEND;
                end else if (count_q != '0) begin
                    pop        = 1'b1;
                    cmd_d      = mem_q[rd_ptr_q];
                    rep_left_d = REP_LOAD;
                    state_d    = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            mem_d[wr_ptr_q] = req_cmd;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // SEND is entered only from IDLE or GAP, so this is a one-cycle pulse.
        start_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            rep_left_q <= '0;
            cmd_q      <= '0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            drop_err_q <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            rep_left_q <= rep_left_d;
            cmd_q      <= cmd_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            drop_err_q <= drop_err_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: tb/tb_fan_cmd_scheduler.sv
// Bench for fan_cmd_scheduler with short packet/gap timing.
// The reference model predicts, for every accepted command, the exact edge of
// each start pulse from the scheduling rule "first start = max(accept+1,
// previous start + period)", and derives occupancy, busy and cmd from that
// schedule.
module tb_fan_cmd_scheduler;

    localparam int PACKET_CYCLES = 10;
    localparam int GAP_CYCLES    = 3;
    localparam int REPEATS       = 2;
    localparam int DEPTH_LOG2    = 2;
    localparam int PERIOD        = 1 + PACKET_CYCLES + GAP_CYCLES;
    localparam int DEPTH         = 1 << DEPTH_LOG2;
    localparam int W             = 35;   // {edge[31:0], cmd[2:0]}

    logic                ref_clk = 1'b0;
    logic                reset   = 1'b1;
    logic                req_valid = 1'b0;
    logic [2:0]          req_cmd = 3'd0;
    logic                req_ready;
    logic [2:0]          cmd;
    logic                start;
    logic                busy;
    logic [DEPTH_LOG2:0] queue_count;
    logic                drop_err;
    logic [1:0]          state_dbg;

    fan_cmd_scheduler #(
        .PACKET_CYCLES(PACKET_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES),
        .REPEATS      (REPEATS),
        .DEPTH_LOG2   (DEPTH_LOG2),
        .TIMER_WIDTH  (17)
    ) dut (
        .ref_clk    (ref_clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_cmd    (req_cmd),
        .req_ready  (req_ready),
        .cmd        (cmd),
        .start      (start),
        .busy       (busy),
        .queue_count(queue_count),
        .drop_err   (drop_err),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 ref_clk = ~ref_clk;

    // ---------------- counters ----------------
    int checks = 0;
    int errors = 0;
    int ecnt   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, ecnt, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         t;
        logic [2:0] c;
    } sched_t;

    logic [W-1:0] exp_q[$];     // start events for the monitor
    sched_t       sched_q[$];   // same events, consumed as time passes
    int           pop_q[$];     // edge at which each queued command leaves
    int           cnt_m      = 0;
    int           last_start = -100000;
    int           cur_start  = -100000;
    logic [2:0]   cur_cmd    = 3'd0;
    int           drop_t     = -1;

    // Handshake seen at the negedge before the coming rising edge.
    bit           p_reset = 1'b1;
    bit           p_acc   = 1'b0;
    logic [2:0]   p_cmd   = 3'd0;

    always @(posedge ref_clk) begin
        int     t0;
        int     dummy;
        sched_t s;
        ecnt++;
        if (p_reset) begin
            exp_q.delete();
            sched_q.delete();
            pop_q.delete();
            cnt_m      = 0;
            last_start = -100000;
            cur_start  = -100000;
            cur_cmd    = 3'd0;
            drop_t     = -1;
        end else if (p_acc) begin
            if (p_cmd <= 3'd4) begin
                t0 = (ecnt + 1 > last_start + PERIOD) ? ecnt + 1 : last_start + PERIOD;
                for (int r = 0; r < REPEATS; r++) begin
                    exp_q.push_back({32'(t0 + r * PERIOD), p_cmd});
                    s.t = t0 + r * PERIOD;
                    s.c = p_cmd;
                    sched_q.push_back(s);
                end
                last_start = t0 + (REPEATS - 1) * PERIOD;
                pop_q.push_back(t0);
                cnt_m++;
            end else begin
                drop_t = ecnt;
            end
        end
        while (pop_q.size() != 0 && pop_q[0] == ecnt) begin
            dummy = pop_q.pop_front();
            cnt_m--;
        end
        while (sched_q.size() != 0 && sched_q[0].t <= ecnt) begin
            s         = sched_q.pop_front();
            cur_start = s.t;
            cur_cmd   = s.c;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge ref_clk) begin
        logic [W-1:0] e;
        int           et;
        if (start) begin
            if (exp_q.size() == 0) begin
                chk("start_unexpected", 1, 0);
            end else begin
                e  = exp_q.pop_front();
                et = int'(e[34:3]);
                chk("start_time", ecnt, et);
                chk("start_cmd", int'(cmd), int'(e[2:0]));
            end
        end
        while (exp_q.size() != 0) begin
            e  = exp_q[0];
            et = int'(e[34:3]);
            if (et >= ecnt) break;
            e = exp_q.pop_front();
            chk("start_missing", ecnt, et);
        end
        chk("cmd", int'(cmd), int'(cur_cmd));
        chk("busy", int'(busy), int'(cur_start > -100000 && ecnt < cur_start + PERIOD));
        chk("queue_count", int'(queue_count), cnt_m);
        chk("req_ready", int'(req_ready), int'(cnt_m != DEPTH));
        chk("drop_err", int'(drop_err), int'(drop_t == ecnt));
        p_reset = reset;
        p_acc   = req_valid && req_ready;
        p_cmd   = req_cmd;
    end

    // ---------------- driver tasks ----------------
    // All drives happen 1 time unit after a rising edge.
    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    task automatic send(input logic [2:0] c);
        int w;
        req_valid = 1'b1;
        req_cmd   = c;
        w = 0;
        while (w < 3000) begin
            @(negedge ref_clk);
            if (req_ready) break;
            w++;
        end
        checks++;
        if (w >= 3000) begin
            errors++;
            $display("FAIL send_timeout at edge %0d: got ready 0 expected ready 1", ecnt);
        end
        @(posedge ref_clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_start();
        int w;
        w = 0;
        do begin
            @(negedge ref_clk);
            w++;
        end while (!start && w < 500);
        checks++;
        if (!start) begin
            errors++;
            $display("FAIL wait_start at edge %0d: got start 0 expected start 1", ecnt);
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 3000) begin
            @(posedge ref_clk);
            w++;
        end
        #1;
        chk("drain_pending", exp_q.size(), 0);
        idle(PERIOD + 4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(posedge ref_clk);
        #1;
        reset = 1'b0;

        // single command
        idle(2);
        send(3'd2);
        drain();

        // ordering
        send(3'd1);
        send(3'd3);
        send(3'd0);
        drain();

        // FIFO fills while the first command plays
        send(3'd4);
        send(3'd0);
        send(3'd1);
        send(3'd2);
        send(3'd3);
        send(3'd4);
        drain();

        // invalid code
        send(3'd6);
        idle(10);

        // reset in the middle of a packet
        send(3'd3);
        send(3'd1);
        wait_start();
        @(posedge ref_clk);
        repeat (3) @(posedge ref_clk);
        #1;
        reset = 1'b1;
        @(posedge ref_clk);
        #1;
        reset = 1'b0;
        idle(30);

        // push coinciding with the pop at the end of the last gap
        send(3'd1);
        send(3'd2);
        wait_start();
        @(posedge ref_clk);
        repeat (2 * PERIOD - 2) @(posedge ref_clk);
        #1;
        send(3'd3);
        drain();

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) < 7) send(3'($urandom_range(0, 7)));
            else idle($urandom_range(1, 20));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
